mem_arbiter: RTL and testbench

Single-port arbiter and access sequencer for the 8-bit processor's data memory. It sits between two requesters and the memory: the pipeline MEM stage (CPU port) and a loader/DMA port. Each access is a one-cycle memory command followed by a fixed read latency, and completion is signalled by an ack pulse. The CPU normally has priority; a starvation counter guarantees DMA progress. It also produces the pipeline stall.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage (CPU) and a loader/DMA port.
// One command cycle per access, fixed read latency, one-cycle ack pulse; CPU priority with DMA anti-starvation.
module mem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int DMA_STARVE = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_ack,
   output logic       cpu_stall,
   input  logic       dma_req,
   input  logic       dma_we,
   input  logic [7:0] dma_addr,
   input  logic [7:0] dma_wdata,
   output logic [7:0] dma_rdata,
   output logic       dma_ack,
   output logic       mem_Rm,
   output logic       mem_Wm,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_RegVal,
   input  logic [7:0] mem_Data_out,
   output logic [1:0] owner
);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] CPU_ACC = 2'b01;
   localparam logic [1:0] DMA_ACC = 2'b10;

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
   localparam logic [3:0] STARVE_LIM = 4'(DMA_STARVE);

   logic [1:0] state;
   logic [3:0] starve_cnt;
   logic [2:0] lat_cnt;
   logic       acc_we;

   logic       cpu_elig;
   logic       dma_elig;
   logic       grant_cpu;
   logic       grant_dma;
   logic       sel_we;
   logic [7:0] sel_addr;
   logic [7:0] sel_wdata;

   // A requester still showing its ack is not eligible, so a req held into the ack cycle cannot re-grant.
   always_comb begin
      cpu_elig  = cpu_req & ~cpu_ack;
      dma_elig  = dma_req & ~dma_ack;
      grant_dma = 1'b0;
      grant_cpu = 1'b0;
      if (state == IDLE) begin
         grant_dma = dma_elig & (~cpu_elig | (starve_cnt == STARVE_LIM));
         grant_cpu = cpu_elig & ~grant_dma;
      end
      sel_we    = grant_dma ? dma_we    : cpu_we;
      sel_addr  = grant_dma ? dma_addr  : cpu_addr;
      sel_wdata = grant_dma ? dma_wdata : cpu_wdata;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         starve_cnt <= '0;
         lat_cnt    <= '0;
         acc_we     <= 1'b0;
         mem_Rm     <= 1'b0;
         mem_Wm     <= 1'b0;
         mem_addr   <= '0;
         mem_RegVal <= '0;
         cpu_rdata  <= '0;
         dma_rdata  <= '0;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
      end else begin
         mem_Rm  <= 1'b0;
         mem_Wm  <= 1'b0;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;

         if (!dma_req || grant_dma) begin
            starve_cnt <= '0;
         end else if (grant_cpu && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
         end

         case (state)
            IDLE: begin
               if (grant_cpu || grant_dma) begin
                  state      <= grant_dma ? DMA_ACC : CPU_ACC;
                  acc_we     <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_RegVal <= sel_wdata;
                  mem_Rm     <= ~sel_we;
                  mem_Wm     <= sel_we;
                  lat_cnt    <= LAT_LOAD;
               end
            end
            CPU_ACC, DMA_ACC: begin
               lat_cnt <= lat_cnt - 3'd1;
               // Last latency edge: memory data is valid now, so capture and finish in one step.
               if (lat_cnt == 3'd1) begin
                  state <= IDLE;
                  if (state == CPU_ACC) begin
                     cpu_ack <= 1'b1;
                     if (!acc_we) cpu_rdata <= mem_Data_out;
                  end else begin
                     dma_ack <= 1'b1;
                     if (!acc_we) dma_rdata <= mem_Data_out;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign owner     = state;
   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3) driven by reactive random requesters,
// every output compared each cycle against a time-stamped access-schedule model.
module tb_mem_arbiter;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;
   localparam int STV0 = 4;
   localparam int STV1 = 2;

   logic       clk = 1'b0;
   logic       resetn;

   // [dut][port], port 0 = CPU, port 1 = DMA
   logic       rq[2][2];
   logic       wq[2][2];
   logic [7:0] ad[2][2];
   logic [7:0] wd[2][2];
   logic [7:0] rd[2][2];
   logic       ak[2][2];
   logic       stall[2];
   logic       m_rm[2];
   logic       m_wm[2];
   logic [7:0] m_addr[2];
   logic [7:0] m_regval[2];
   logic [7:0] m_dout[2];
   logic [1:0] own[2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LAT(LAT0), .DMA_STARVE(STV0)) u_lat1 (
      .clock(clk), .resetn(resetn),
      .cpu_req(rq[0][0]), .cpu_we(wq[0][0]), .cpu_addr(ad[0][0]), .cpu_wdata(wd[0][0]),
      .cpu_rdata(rd[0][0]), .cpu_ack(ak[0][0]), .cpu_stall(stall[0]),
      .dma_req(rq[0][1]), .dma_we(wq[0][1]), .dma_addr(ad[0][1]), .dma_wdata(wd[0][1]),
      .dma_rdata(rd[0][1]), .dma_ack(ak[0][1]),
      .mem_Rm(m_rm[0]), .mem_Wm(m_wm[0]), .mem_addr(m_addr[0]), .mem_RegVal(m_regval[0]),
      .mem_Data_out(m_dout[0]), .owner(own[0])
   );

   mem_arbiter #(.MEM_LAT(LAT1), .DMA_STARVE(STV1)) u_lat3 (
      .clock(clk), .resetn(resetn),
      .cpu_req(rq[1][0]), .cpu_we(wq[1][0]), .cpu_addr(ad[1][0]), .cpu_wdata(wd[1][0]),
      .cpu_rdata(rd[1][0]), .cpu_ack(ak[1][0]), .cpu_stall(stall[1]),
      .dma_req(rq[1][1]), .dma_we(wq[1][1]), .dma_addr(ad[1][1]), .dma_wdata(wd[1][1]),
      .dma_rdata(rd[1][1]), .dma_ack(ak[1][1]),
      .mem_Rm(m_rm[1]), .mem_Wm(m_wm[1]), .mem_addr(m_addr[1]), .mem_RegVal(m_regval[1]),
      .mem_Data_out(m_dout[1]), .owner(own[1])
   );

   function automatic int lat_of(input int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int stv_of(input int i);
      return (i == 0) ? STV0 : STV1;
   endfunction

   function automatic logic [7:0] pat(input int a);
      logic [7:0] v;
      v = 8'(a * 37 + 11);
      if (a == 16) v = 8'h5A;
      return v;
   endfunction

   function automatic logic [16:0] dir_cmd(input int k);
      case (k)
         0:       return {1'b0, 8'h10, 8'h00};
         1:       return {1'b1, 8'h20, 8'h33};
         default: return {1'b0, 8'h20, 8'h00};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Memory seen by the DUTs: combinational read on the held address, write on the strobe cycle.
   logic [7:0] t_mem[2][256];
   bit         t_init = 1'b0;
   always @(posedge clk) begin
      if (!t_init) begin
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) t_mem[i][a] <= pat(a);
         t_init <= 1'b1;
      end
      for (int i = 0; i < 2; i++)
         if (m_wm[i]) t_mem[i][m_addr[i]] <= m_regval[i];
   end
   assign m_dout[0] = t_mem[0][m_addr[0]];
   assign m_dout[1] = t_mem[1][m_addr[1]];

   // Reference model: each access is a record with its grant edge and completion edge (grant + MEM_LAT).
   int         cyc = 0;
   bit         m_init = 1'b0;
   logic [7:0] m_mem[2][256];
   bit         e_act[2];
   int         e_end[2];
   int         e_port[2];
   bit         e_we[2];
   int         starve[2];
   int         x_own[2];
   bit         x_rm[2];
   bit         x_wm[2];
   logic [7:0] x_addr[2];
   logic [7:0] x_regval[2];
   logic [7:0] x_rd[2][2];
   bit         x_ak[2][2];
   bit         ce, de, gc, gd;
   int         pw;

   always @(posedge clk) begin
      cyc++;
      if (!m_init) begin
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) m_mem[i][a] = pat(a);
         m_init = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
         if (!resetn) begin
            e_act[i] = 0; x_own[i] = 0; x_rm[i] = 0; x_wm[i] = 0;
            x_addr[i] = 8'h00; x_regval[i] = 8'h00; starve[i] = 0;
            for (int p = 0; p < 2; p++) begin
               x_rd[i][p] = 8'h00;
               x_ak[i][p] = 0;
            end
         end else begin
            ce = rq[i][0] && !x_ak[i][0];
            de = rq[i][1] && !x_ak[i][1];
            gc = 0; gd = 0;
            x_rm[i] = 0; x_wm[i] = 0; x_ak[i][0] = 0; x_ak[i][1] = 0;
            if (e_act[i] && cyc == e_end[i]) begin
               if (!e_we[i]) x_rd[i][e_port[i]] = m_mem[i][x_addr[i]];
               x_ak[i][e_port[i]] = 1;
               e_act[i] = 0;
               x_own[i] = 0;
            end else if (!e_act[i]) begin
               gd = de && (!ce || starve[i] == stv_of(i));
               gc = ce && !gd;
               if (gc || gd) begin
                  pw = gd ? 1 : 0;
                  e_port[i]   = pw;
                  e_we[i]     = wq[i][pw];
                  x_addr[i]   = ad[i][pw];
                  x_regval[i] = wd[i][pw];
                  if (wq[i][pw]) begin
                     m_mem[i][ad[i][pw]] = wd[i][pw];
                     x_wm[i] = 1;
                  end else begin
                     x_rm[i] = 1;
                  end
                  e_end[i] = cyc + lat_of(i);
                  e_act[i] = 1;
                  x_own[i] = pw + 1;
               end
            end
            if (!rq[i][1] || gd) starve[i] = 0;
            else if (gc && starve[i] < stv_of(i)) starve[i]++;
         end
      end
   end

   // Requester behaviour knobs, set by the main sequence.
   bit  chk_en = 1'b0;
   bit  en[2];
   int  rate = 0;
   bit  dma_rd_only = 1'b0;
   int  dir_ptr[2];
   bit  linger[2][2];

   task automatic get_cmd(input int i, input int p, input bit force_new,
                          output bit ok, output logic w, output logic [7:0] a, output logic [7:0] d);
      logic [16:0] c;
      ok = 0; w = 0; a = 8'h00; d = 8'h00;
      if (p == 0 && dir_ptr[i] < 3) begin
         c = dir_cmd(dir_ptr[i]);
         dir_ptr[i]++;
         w = c[16]; a = c[15:8]; d = c[7:0];
         ok = 1;
      end else if (en[p] && (force_new || $urandom_range(0, 99) < rate)) begin
         w = (p == 1 && dma_rd_only) ? 1'b0 : 1'($urandom_range(0, 1));
         a = 8'h10 + 8'($urandom_range(0, 15));
         d = 8'($urandom);
         ok = 1;
      end
   endtask

   bit         ok;
   logic       nw;
   logic [7:0] na, nd;
   int         act;

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_owner", i), 32'(own[i]), 32'(x_own[i]));
            check($sformatf("d%0d_mem_Rm", i), 32'(m_rm[i]), 32'(x_rm[i]));
            check($sformatf("d%0d_mem_Wm", i), 32'(m_wm[i]), 32'(x_wm[i]));
            check($sformatf("d%0d_mem_addr", i), 32'(m_addr[i]), 32'(x_addr[i]));
            check($sformatf("d%0d_mem_RegVal", i), 32'(m_regval[i]), 32'(x_regval[i]));
            check($sformatf("d%0d_cpu_rdata", i), 32'(rd[i][0]), 32'(x_rd[i][0]));
            check($sformatf("d%0d_dma_rdata", i), 32'(rd[i][1]), 32'(x_rd[i][1]));
            check($sformatf("d%0d_cpu_ack", i), 32'(ak[i][0]), 32'(x_ak[i][0]));
            check($sformatf("d%0d_dma_ack", i), 32'(ak[i][1]), 32'(x_ak[i][1]));
            check($sformatf("d%0d_cpu_stall", i), 32'(stall[i]), 32'(rq[i][0] && !x_ak[i][0]));
         end
      end
      if (resetn) begin
         for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
               if (ak[i][p]) begin
                  act = $urandom_range(0, 2);
                  if (act == 1) begin
                     linger[i][p] = 1;
                  end else if (act == 2) begin
                     get_cmd(i, p, 1'b1, ok, nw, na, nd);
                     if (ok) begin
                        wq[i][p] = nw; ad[i][p] = na; wd[i][p] = nd;
                     end else begin
                        rq[i][p] = 0;
                     end
                  end else begin
                     rq[i][p] = 0;
                  end
               end else if (linger[i][p]) begin
                  linger[i][p] = 0;
                  rq[i][p] = 0;
               end else if (rq[i][p]) begin
                  if (own[i] == 2'(p + 1) && $urandom_range(0, 1) == 1) begin
                     wq[i][p] = 1'($urandom);
                     ad[i][p] = 8'($urandom);
                     wd[i][p] = 8'($urandom);
                  end
               end else begin
                  get_cmd(i, p, 1'b0, ok, nw, na, nd);
                  if (ok) begin
                     rq[i][p] = 1; wq[i][p] = nw; ad[i][p] = na; wd[i][p] = nd;
                  end
               end
            end
         end
      end
   end

   bit found;

   initial begin
      resetn = 1'b0;
      en[0] = 0; en[1] = 0;
      dir_ptr[0] = 0; dir_ptr[1] = 0;
      for (int i = 0; i < 2; i++)
         for (int p = 0; p < 2; p++) begin
            rq[i][p] = 0; wq[i][p] = 0; ad[i][p] = 8'h00; wd[i][p] = 8'h00; linger[i][p] = 0;
         end
      repeat (2) @(posedge clk);
      @(negedge clk); #2 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;

      // CPU-only directed: read 0x10, write 0x33 to 0x20, read 0x20
      repeat (30) @(negedge clk);

      // Both requesters hold req continuously; the ack cycle hands the next slot to the other port
      en[0] = 1; en[1] = 1; rate = 100;
      repeat (80) @(negedge clk);

      rate = 35;
      repeat (800) @(negedge clk);

      // Reset during a DMA read on the MEM_LAT=3 instance
      en[0] = 0; dma_rd_only = 1'b1; rate = 100;
      repeat (20) @(negedge clk);
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (own[1] == 2'b10 && m_rm[1]) found = 1;
      end
      check("rst_wait_dma_read", 32'(found), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check("rst_async_Rm", 32'(m_rm[1]), 32'd0);
      check("rst_async_owner", 32'(own[1]), 32'd0);
      check("rst_async_dma_ack", 32'(ak[1][1]), 32'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      repeat (40) @(negedge clk);

      en[1] = 0;
      repeat (20) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
